// File: rtl/mean_replay_unit.sv
// Captures one block of samples, computes the truncated block mean, then replays
// the stored samples framed with a start strobe while the mean is held stable.
module mean_replay_unit #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  start_data_out,
  output logic                  data_valid_out,
  output logic [DATA_WIDTH-1:0] mean_out,
  output logic                  mean_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(TOTAL_SAMPLES);
  localparam int ACC_W = DATA_WIDTH + CNT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DIVIDE, REPLAY} state_t;

  // Power-of-two block length turns the mean into a plain truncating shift.
  function automatic logic [DATA_WIDTH-1:0] trunc_mean(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:CNT_W];
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    start_out_q, start_out_d;
  logic                    dvalid_q, dvalid_d;
  logic [DATA_WIDTH-1:0]   mean_q, mean_d;
  logic                    mean_valid_q, mean_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    wr_en;
  logic [CNT_W-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]   buf_q [TOTAL_SAMPLES];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    mean_d       = mean_q;
    mean_valid_d = 1'b0;
    data_out_d   = '0;
    start_out_d  = 1'b0;
    dvalid_d     = 1'b0;
    overrun_d    = start_data_in && (state_q != IDLE);
    wr_en        = 1'b0;
    wr_addr      = idx_q;
    case (state_q)
      IDLE: begin
        if (start_data_in) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          acc_d   = {{CNT_W{1'b0}}, data_in};
          idx_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        wr_en = 1'b1;
        acc_d = acc_q + {{CNT_W{1'b0}}, data_in};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DIVIDE;
      end
      DIVIDE: begin
        mean_d       = trunc_mean(acc_q);
        mean_valid_d = 1'b1;
        idx_d        = '0;
        state_d      = REPLAY;
      end
      REPLAY: begin
        data_out_d  = buf_q[idx_q];
        dvalid_d    = 1'b1;
        start_out_d = (idx_q == '0);
        idx_d       = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      data_out_q   <= '0;
      start_out_q  <= 1'b0;
      dvalid_q     <= 1'b0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      start_out_q  <= start_out_d;
      dvalid_q     <= dvalid_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // Sample storage carries no reset; stale contents are never replayed.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= data_in;
  end

  assign data_out       = data_out_q;
  assign start_data_out = start_out_q;
  assign data_valid_out = dvalid_q;
  assign mean_out       = mean_q;
  assign mean_valid     = mean_valid_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_mean_replay_unit.sv
// Randomized and directed bench for mean_replay_unit with a block-level reference model.
module tb_mean_replay_unit;

  localparam int DW = 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          start_data_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          start_data_out;
  logic          data_valid_out;
  logic [DW-1:0] mean_out;
  logic          mean_valid;
  logic          busy;
  logic          overrun;

  mean_replay_unit #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .start_data_in  (start_data_in),
    .data_out       (data_out),
    .start_data_out (start_data_out),
    .data_valid_out (data_valid_out),
    .mean_out       (mean_out),
    .mean_valid     (mean_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a block is the cycle it was accepted plus the samples it captured.
  int            cyc = 0;
  int            blk = -1;
  int            samples[$];
  logic [DW-1:0] e_mean = '0;
  logic          e_mv = 1'b0, e_dv = 1'b0, e_sdo = 1'b0, e_busy = 1'b0, e_ovr = 1'b0;
  logic [DW-1:0] e_dout = '0;

  always @(posedge clk) begin
    int rel;
    int sum;
    cyc++;
    if (rst) begin
      blk = -1;
      samples.delete();
      e_mean = '0;
      e_mv = 0; e_dv = 0; e_sdo = 0; e_busy = 0; e_ovr = 0; e_dout = '0;
    end else begin
      rel = (blk >= 0) ? cyc - blk : -1;
      e_ovr = start_data_in && (rel >= 1) && (rel <= 2*T);
      if (start_data_in && (blk < 0 || rel >= 2*T+1)) begin
        blk = cyc;
        rel = 0;
        samples.delete();
      end
      if (rel >= 0 && rel < T) samples.push_back(int'(data_in));
      e_mv = (rel == T);
      if (e_mv) begin
        sum = 0;
        foreach (samples[j]) sum += samples[j];
        e_mean = DW'(sum / T);
      end
      e_dv   = (rel >= T+1) && (rel <= 2*T);
      e_dout = e_dv ? DW'(samples[rel-T-1]) : '0;
      e_sdo  = (rel == T+1);
      e_busy = (rel >= 0) && (rel <= 2*T-1);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("data_out",       32'(data_out),       32'(e_dout));
      chk("start_data_out", 32'(start_data_out), 32'(e_sdo));
      chk("data_valid_out", 32'(data_valid_out), 32'(e_dv));
      chk("mean_out",       32'(mean_out),       32'(e_mean));
      chk("mean_valid",     32'(mean_valid),     32'(e_mv));
      chk("busy",           32'(busy),           32'(e_busy));
      chk("overrun",        32'(overrun),        32'(e_ovr));
    end
  end

  task automatic drive(input logic r, input logic s, input logic [DW-1:0] d);
    @(posedge clk);
    #2;
    rst = r;
    start_data_in = s;
    data_in = d;
  endtask

  // kind 0: ramp from base, 1: constant base, 2: random samples
  task automatic run_block(input int kind, input int base, input bit ovr,
                           input int rst_at, input bit rnd_ovr);
    logic          s, r;
    logic [DW-1:0] d;
    for (int i = 0; i <= 2*T; i++) begin
      s = (i == 0);
      if (ovr && (i == 5 || i == 20)) s = 1'b1;
      if (rnd_ovr && i > 0 && $urandom_range(0, 5) == 0) s = 1'b1;
      r = (i == rst_at);
      if (rst_at >= 0 && i > rst_at) s = 1'b0;
      if (i < T) begin
        case (kind)
          0:       d = DW'(base + i);
          1:       d = DW'(base);
          default: d = DW'($urandom);
        endcase
      end else begin
        d = DW'($urandom);
      end
      drive(r, s, d);
    end
  endtask

  initial begin
    repeat (3) drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_mean", 32'(mean_out), 0);

    run_block(0, 1, 0, -1, 0);
    chk("lit_ramp1_mean", 32'(mean_out), 8);
    run_block(0, 11, 0, -1, 0);
    chk("lit_ramp11_mean", 32'(mean_out), 18);
    run_block(1, 6, 0, -1, 0);
    chk("lit_const6_mean", 32'(mean_out), 6);
    run_block(1, 255, 0, -1, 0);
    chk("lit_all255_mean", 32'(mean_out), 255);
    run_block(1, 0, 0, -1, 0);
    chk("lit_zero_mean", 32'(mean_out), 0);
    run_block(0, 1, 1, -1, 0);
    chk("lit_overrun_mean", 32'(mean_out), 8);

    run_block(0, 1, 0, 7, 0);
    chk("lit_rst_busy", 32'(busy), 0);
    chk("lit_rst_valid", 32'(data_valid_out), 0);
    chk("lit_rst_mean", 32'(mean_out), 0);
    run_block(0, 1, 0, -1, 0);
    chk("lit_after_rst_mean", 32'(mean_out), 8);

    for (int b = 0; b < 20; b++) begin
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, DW'($urandom));
      run_block(2, 0, 0, (b % 7 == 3) ? int'($urandom_range(1, 31)) : -1, 1'b1);
    end
    repeat (4) drive(1'b0, 1'b0, '0);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
